// File: rtl/fixed_point_euler_step.sv
// Fixed-point forward-Euler integrator: y += (slope * h) >>> FRAC_BITS per step, slope fetched from an upstream divider.
// Define EULER_STEP_SAT_EN to clamp overflowing products/sums and flag sat; otherwise results wrap.
`timescale 1ns/1ps
module fixed_point_euler_step #(
    parameter int unsigned FRAC_BITS = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] y0,
    input  logic [15:0] h,
    input  logic [15:0] n_steps,
    output logic        req_valid,
    input  logic [15:0] slope,
    input  logic        slope_ovf,
    input  logic        slope_valid,
    output logic        slope_ready,
    output logic [15:0] y_out,
    output logic [15:0] step_cnt,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        sat
);

    localparam int unsigned DW = 16;
    localparam int unsigned PW = 2 * DW;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_MUL,
        ST_ACC,
        ST_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   h_q, h_d;
    logic [DW-1:0]   n_q, n_d;
    logic [DW-1:0]   slope_q, slope_d;
    logic [DW-1:0]   prod_q, prod_d;
    logic [DW-1:0]   y_d, cnt_d;
    logic            err_d, sat_d, busy_d, done_d, req_valid_d, slope_ready_d;
    logic signed [PW-1:0] prod_full;

`ifdef EULER_STEP_SAT_EN
    localparam logic signed [PW-1:0] PMAX = 32'sh0000_7FFF;
    localparam logic signed [PW-1:0] PMIN = -32'sh0000_8000;
    logic signed [PW-1:0] prod_sh;
    logic signed [DW:0]   sum;
`endif

    // Next-state and next-output logic; every register has a _d computed here
    always_comb begin
        state_d   = state_q;
        h_d       = h_q;
        n_d       = n_q;
        slope_d   = slope_q;
        prod_d    = prod_q;
        y_d       = y_out;
        cnt_d     = step_cnt;
        err_d     = err;
        sat_d     = sat;
        prod_full = $signed({{DW{slope_q[DW-1]}}, slope_q}) * $signed({{DW{h_q[DW-1]}}, h_q});
`ifdef EULER_STEP_SAT_EN
        prod_sh   = prod_full >>> FRAC_BITS;
        sum       = $signed({y_out[DW-1], y_out}) + $signed({prod_q[DW-1], prod_q});
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    y_d     = y0;
                    h_d     = h;
                    n_d     = n_steps;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    sat_d   = 1'b0;
                    state_d = (n_steps != '0) ? ST_WAIT : ST_DONE;
                end
            end
            ST_WAIT: begin
                if (slope_valid) begin
                    if (slope_ovf) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        slope_d = slope;
                        state_d = ST_MUL;
                    end
                end
            end
            ST_MUL: begin
`ifdef EULER_STEP_SAT_EN
                if (prod_sh > PMAX) begin
                    prod_d = 16'h7FFF;
                    sat_d  = 1'b1;
                end else if (prod_sh < PMIN) begin
                    prod_d = 16'h8000;
                    sat_d  = 1'b1;
                end else begin
                    prod_d = prod_sh[DW-1:0];
                end
`else
                prod_d = DW'(prod_full >>> FRAC_BITS);
`endif
                state_d = ST_ACC;
            end
            ST_ACC: begin
`ifdef EULER_STEP_SAT_EN
                // Overflow when the two top bits of the 17-bit sum disagree
                if (sum[DW] != sum[DW-1]) begin
                    y_d   = sum[DW] ? 16'h8000 : 16'h7FFF;
                    sat_d = 1'b1;
                end else begin
                    y_d = sum[DW-1:0];
                end
`else
                y_d = y_out + prod_q;
`endif
                cnt_d   = step_cnt + 16'd1;
                state_d = (cnt_d == n_q) ? ST_DONE : ST_WAIT;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifndef EULER_STEP_SAT_EN
        sat_d = 1'b0;
`endif

        // Status outputs are registered copies of the decoded next state
        busy_d        = (state_d != ST_IDLE);
        done_d        = (state_d == ST_DONE);
        req_valid_d   = (state_d == ST_WAIT);
        slope_ready_d = (state_d == ST_WAIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            h_q         <= '0;
            n_q         <= '0;
            slope_q     <= '0;
            prod_q      <= '0;
            y_out       <= '0;
            step_cnt    <= '0;
            err         <= 1'b0;
            sat         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            req_valid   <= 1'b0;
            slope_ready <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            n_q         <= n_d;
            slope_q     <= slope_d;
            prod_q      <= prod_d;
            y_out       <= y_d;
            step_cnt    <= cnt_d;
            err         <= err_d;
            sat         <= sat_d;
            busy        <= busy_d;
            done        <= done_d;
            req_valid   <= req_valid_d;
            slope_ready <= slope_ready_d;
        end
    end

endmodule

// File: doc/fixed_point_euler_step.md
FIXED_POINT_EULER_STEP -- requirements
Module: fixed_point_euler_step

Interface
REQ-001 Parameter FRAC_BITS, default 7, SHALL be the fractional bit count of all Q-format data; total data width is fixed at 16 bits signed.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  begin a run; sampled only in IDLE.
REQ-005 y0  input  16  signed initial state, Q8.7; captured on accepted start.
REQ-006 h  input  16  signed step size, Q8.7; captured on accepted start.
REQ-007 n_steps  input  16  unsigned step count; captured on accepted start.
REQ-008 req_valid  output  1  request to upstream divider stage: evaluate slope at y_out.
REQ-009 slope  input  16  signed slope from divider, Q8.7.
REQ-010 slope_ovf  input  1  divider overflow / divide-by-zero flag, qualified by slope_valid.
REQ-011 slope_valid  input  1  slope and slope_ovf valid.
REQ-012 slope_ready  output  1  block accepts slope this cycle.
REQ-013 y_out  output  16  current integrated state, Q8.7.
REQ-014 step_cnt  output  16  completed steps in current run.
REQ-015 busy  output  1  high in any state except IDLE.
REQ-016 done  output  1  one-cycle pulse on normal completion.
REQ-017 err  output  1  sticky: run aborted by slope_ovf; cleared on next accepted start.
REQ-018 sat  output  1  sticky: at least one accumulation saturated this run; cleared on accepted start.

Function
REQ-019 FSM states SHALL be IDLE, WAIT, MUL, ACC, DONE.
REQ-020 IDLE: start=1 loads y=y0, h, n_steps, step_cnt=0, clears err/sat; next state WAIT if n_steps!=0, else DONE.
REQ-021 WAIT: req_valid=1 and slope_ready=1; transfer occurs when slope_valid=1 in the same cycle.
REQ-022 On transfer with slope_ovf=1: set err, return to IDLE, y_out and step_cnt hold; no done pulse.
REQ-023 On transfer with slope_ovf=0: register slope, go to MUL.
REQ-024 MUL: register product = slope*h as 32-bit signed, arithmetic-shift right by FRAC_BITS (truncate toward minus infinity); go to ACC.
REQ-025 ACC: y = y + product with 17-bit intermediate handled per REQ-033/034; step_cnt+1; next DONE if new step_cnt==n_steps else WAIT.
REQ-026 Per-step latency SHALL be 3 cycles from transfer to y_out update (WAIT→MUL→ACC, updated on ACC exit edge).
REQ-027 DONE: done=1 for exactly one cycle, then IDLE.
REQ-028 slope_valid outside WAIT SHALL be ignored; req_valid and slope_ready SHALL be 0 outside WAIT.
REQ-029 start while busy=1 SHALL be ignored; start and DONE coinciding is not accepted until IDLE.
REQ-030 y_out and step_cnt SHALL hold final values in IDLE until next accepted start.

Reset
REQ-031 rst_n=0 at any time, including mid-run, SHALL immediately force state IDLE, y_out=0, step_cnt=0, req_valid=0, slope_ready=0, busy=0, done=0, err=0, sat=0.
REQ-032 First accepted start SHALL be one edge after rst_n deasserts at the earliest.

Configuration
REQ-033 With EULER_STEP_SAT_EN defined: sum or shifted product exceeding 16-bit range SHALL clamp to 0x7FFF / 0x8000 and set sat.
REQ-034 Without EULER_STEP_SAT_EN: result SHALL wrap (low 16 bits), sat tied to 0.

Verification
REQ-035 y0=0x0080, h=0x0040, n=1, slope=0x0100 ovf=0 → y_out=0x0100, step_cnt=1, done pulse 3 cycles after transfer+1.
REQ-036 n_steps=0, start → DONE next cycle, done pulse, req_valid never asserted, y_out=y0.
REQ-037 SAT_EN: y0=0x7F00, h=0x0080, slope=0x7FFF, n=1 → y_out=0x7FFF, sat=1; without macro y_out=0xFEFF, sat=0.
REQ-038 n=3, second slope returned with slope_ovf=1 → err=1, step_cnt=1, IDLE, no done; next start clears err.
REQ-039 slope=0xFFFF, h=0x0040, y0=0x0000, n=1 → y_out=0xFFFF (truncation toward minus infinity).
REQ-040 rst_n pulsed low during MUL of step 2 → all outputs per REQ-031 asynchronously; later start runs normally.
